dma_write_block: RTL and testbench

Write-side engine of the scatter-gather DMA and the mirror of the DMA read block. Queues write commands (destination address, byte count) from the descriptor processor in an internal command FIFO. Drains 256-bit words from the DMA data FIFO (show-ahead) and issues one Avalon-MM burst write per command. Pulses done per completed command back to the descriptor processor.

---
 rtl/dma_pkg.sv | 38 +++
 rtl/dma_wr_cmd_fifo.sv | 62 ++++++
 rtl/dma_write_block.sv | 136 +++++++++++++
 tb/tb_dma_write_block.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA write engine.
package dma_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LD_CMD = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } wr_state_e;

   localparam int BEAT_BYTES   = 32;
   localparam int DATA_W       = 256;
   localparam int BE_W         = 32;
   localparam int BCOUNT_W     = 11;
   localparam int MAX_WR_BYTES = 65504;

   // Command entry layout: {bytes[15:0], addr[31:0]}
   localparam int CMD_ADDR_LSB  = 0;
   localparam int CMD_ADDR_W    = 32;
   localparam int CMD_BYTES_LSB = 32;
   localparam int CMD_BYTES_W   = 16;
   localparam int CMD_W         = CMD_ADDR_W + CMD_BYTES_W;

   typedef struct packed {
      logic [CMD_BYTES_W-1:0] bytes;
      logic [CMD_ADDR_W-1:0]  addr;
   } wr_cmd_t;

   // Byte enables for the final beat: full word when the byte count is a
   // whole number of beats, otherwise only the low 'tail' bytes.
   function automatic logic [BE_W-1:0] last_beat_be(input logic [4:0] tail);
      logic [BE_W-1:0] one;
      one = {{(BE_W-1){1'b0}}, 1'b1};
      if (tail == 5'd0) return '1;
      return (one << tail) - one;
   endfunction

endpackage

// File: rtl/dma_wr_cmd_fifo.sv
// Show-ahead synchronous command FIFO with registered full/empty flags.
// Async reset empties it so no stale command survives a reset.
module dma_wr_cmd_fifo #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int W     = 48
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          do_push, do_pop;

   // Pointer/count update; a push while full or pop while empty is dropped.
   always_comb begin
      do_push  = push_i & ~full_q;
      do_pop   = pop_i & ~empty_q;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
   end

   // Control state with async clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset; the empty flag guards reads.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/dma_write_block.sv
// DMA write engine: queues write commands, drains the show-ahead data FIFO
// and issues one Avalon-MM burst per command, pulsing done (or err) at the end.
module dma_write_block
   import dma_pkg::*;
#(
   parameter int CMD_FIFO_DEPTH = 32,
   parameter int CMD_FIFO_AW    = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                dma_wr_fifo_command_req_i,
   input  logic [15:0]         dma_wr_bytes_to_transfer_i,
   input  logic [31:0]         dma_wr_addr_i,
   output logic                dma_wr_fifo_full_o,
   input  logic [DATA_W-1:0]   dma_wr_data_i,
   input  logic                dma_wr_data_empty_i,
   output logic                dma_wr_data_rd_o,
   output logic                wr_master_wr_o,
   output logic [31:0]         wr_master_addr_o,
   output logic [BCOUNT_W-1:0] wr_master_bcount_o,
   output logic [DATA_W-1:0]   wr_master_data_o,
   output logic [BE_W-1:0]     wr_master_byteen_o,
   input  logic                wr_master_wait_req_i,
   output logic                dma_wr_done_o,
   output logic                dma_wr_err_o,
   output logic                dma_wr_busy_o
);
   wr_state_e             state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic [15:0]           bytes_q, bytes_d;
   logic [BCOUNT_W-1:0]   bcount_q, bcount_d;
   logic [BCOUNT_W-1:0]   remain_q, remain_d;
   logic [BE_W-1:0]       last_be_q, last_be_d;
   wr_cmd_t               fifo_head;
   logic                  fifo_pop, fifo_empty, fifo_full;
   logic [BCOUNT_W:0]     beats;

   dma_wr_cmd_fifo #(
      .DEPTH (CMD_FIFO_DEPTH),
      .AW    (CMD_FIFO_AW),
      .W     (CMD_W)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (dma_wr_fifo_command_req_i),
      .wdata_i ({dma_wr_bytes_to_transfer_i, dma_wr_addr_i}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // One extra bit so a 65505..65535 byte count shows up as 2048 beats.
   assign beats = {1'b0, bytes_q[15:5]} + {{BCOUNT_W{1'b0}}, |bytes_q[4:0]};

   // Next-state and bus outputs.
   always_comb begin
      state_d            = state_q;
      addr_d             = addr_q;
      bytes_d            = bytes_q;
      bcount_d           = bcount_q;
      remain_d           = remain_q;
      last_be_d          = last_be_q;
      fifo_pop           = 1'b0;
      wr_master_wr_o     = 1'b0;
      dma_wr_data_rd_o   = 1'b0;
      wr_master_data_o   = '0;
      wr_master_byteen_o = '0;
      dma_wr_done_o      = 1'b0;
      dma_wr_err_o       = 1'b0;
      case (state_q)
         IDLE: begin
            // The head is captured as it is popped; show-ahead moves on next cycle.
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               addr_d   = fifo_head.addr;
               bytes_d  = fifo_head.bytes;
               state_d  = LD_CMD;
            end
         end
         LD_CMD: begin
            if (bytes_q == '0) begin
               state_d = DONE;
            end else if (bytes_q > 16'(MAX_WR_BYTES)) begin
               dma_wr_err_o = 1'b1;
               state_d      = IDLE;
            end else begin
               bcount_d  = beats[BCOUNT_W-1:0];
               remain_d  = beats[BCOUNT_W-1:0];
               last_be_d = last_beat_be(bytes_q[4:0]);
               state_d   = WRITE;
            end
         end
         WRITE: begin
            wr_master_wr_o     = ~dma_wr_data_empty_i;
            wr_master_data_o   = dma_wr_data_i;
            wr_master_byteen_o = (remain_q == BCOUNT_W'(1)) ? last_be_q : '1;
            if (wr_master_wr_o && !wr_master_wait_req_i) begin
               dma_wr_data_rd_o = 1'b1;
               remain_d         = remain_q - BCOUNT_W'(1);
               if (remain_q == BCOUNT_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            dma_wr_done_o = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Engine registers; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         bytes_q   <= '0;
         bcount_q  <= '0;
         remain_q  <= '0;
         last_be_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         bytes_q   <= bytes_d;
         bcount_q  <= bcount_d;
         remain_q  <= remain_d;
         last_be_q <= last_be_d;
      end
   end

   assign wr_master_addr_o   = addr_q;
   assign wr_master_bcount_o = bcount_q;
   assign dma_wr_fifo_full_o = fifo_full;
   assign dma_wr_busy_o      = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_dma_write_block.sv
// Randomized bench for dma_write_block with a timestamp-based reference model.
module tb_dma_write_block;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         cmd_req = 1'b0;
   logic [15:0]  cmd_bytes = '0;
   logic [31:0]  cmd_addr = '0;
   logic         full;
   logic [255:0] data_i = '0;
   logic         data_empty = 1'b1;
   logic         rd, wr;
   logic [31:0]  m_addr;
   logic [10:0]  bcount;
   logic [255:0] m_data;
   logic [31:0]  byteen;
   logic         wait_req = 1'b0;
   logic         done, err, busy;

   always #5 clk = ~clk;

   dma_write_block dut (
      .clk                        (clk),
      .reset_n                    (reset_n),
      .dma_wr_fifo_command_req_i  (cmd_req),
      .dma_wr_bytes_to_transfer_i (cmd_bytes),
      .dma_wr_addr_i              (cmd_addr),
      .dma_wr_fifo_full_o         (full),
      .dma_wr_data_i              (data_i),
      .dma_wr_data_empty_i        (data_empty),
      .dma_wr_data_rd_o           (rd),
      .wr_master_wr_o             (wr),
      .wr_master_addr_o           (m_addr),
      .wr_master_bcount_o         (bcount),
      .wr_master_data_o           (m_data),
      .wr_master_byteen_o         (byteen),
      .wr_master_wait_req_i       (wait_req),
      .dma_wr_done_o              (done),
      .dma_wr_err_o               (err),
      .dma_wr_busy_o              (busy)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [255:0] rword();
      logic [255:0] w;
      for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // ---------------- data FIFO environment ----------------
   logic [255:0] dq[$];
   bit           wait_s[$];
   bit           starve_s[$];
   bit           auto_fill = 0;
   int           wait_pct = 0;
   int           starve_pct = 0;
   bit           rd_seen = 0;

   // Applies the pop seen last cycle, then presents this cycle's inputs.
   always @(posedge clk) begin
      bit starve;
      #2;
      if (rd_seen && dq.size() > 0) void'(dq.pop_front());
      if (auto_fill && dq.size() < 8 && $urandom_range(0, 2) != 0) dq.push_back(rword());
      wait_req = (wait_s.size() > 0) ? wait_s.pop_front() : ($urandom_range(0, 99) < wait_pct);
      starve   = (starve_s.size() > 0) ? starve_s.pop_front() : ($urandom_range(0, 99) < starve_pct);
      data_empty = starve || (dq.size() == 0);
      data_i     = (dq.size() > 0) ? dq[0] : rword();
   end

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned bytes;
      logic [31:0] addr;
      int          pc;
   } cmd_t;

   cmd_t        q[$];
   cmd_t        jc;
   bit          job = 0;
   int          wfrom = 0, left = 0, total = 0;
   int          done_at = -10, err_at = -10, free_at = 0;
   int          n_done = 0, n_err = 0, n_beats = 0, n_pops = 0;
   logic [31:0] seen_be = '0, seen_addr = '0;
   logic [10:0] seen_bc = '0;

   function automatic logic [31:0] model_last_be(input int unsigned b);
      logic [31:0] one;
      one = 32'd1;
      if (b % 32 == 0) return 32'hFFFF_FFFF;
      return (one << (b % 32)) - one;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      bit ew;
      int sz;
      if (!reset_n) begin
         chk("rst_wr", wr, 0);
         chk("rst_rd", rd, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_busy", busy, 0);
         chk("rst_full", full, 0);
         chk("rst_addr", m_addr, 0);
         chk("rst_bcount", bcount, 0);
         chk("rst_byteen", byteen, 0);
         q.delete();
         job = 0; done_at = -10; err_at = -10; free_at = 0;
         rd_seen = 0;
      end else begin
         sz = q.size();
         ew = job && (cyc >= wfrom) && !data_empty;
         chk("wr", wr, ew);
         chk("rd", rd, ew && !wait_req);
         chk("done", done, cyc == done_at);
         chk("err", err, cyc == err_at);
         chk("busy", busy, job || (cyc < free_at) || (sz > 0 && q[0].pc < cyc));
         chk("full", full, sz == 32);
         if (ew) begin
            chk("addr", m_addr, jc.addr);
            chk("bcount", bcount, total);
            chk("data", m_data, dq[0]);
            chk("byteen", byteen, (left == 1) ? model_last_be(jc.bytes) : 32'hFFFF_FFFF);
         end
         if (done) n_done++;
         if (err) n_err++;
         if (rd) n_pops++;
         if (wr && !wait_req) begin
            n_beats++;
            seen_be = byteen; seen_addr = m_addr; seen_bc = bcount;
         end
         rd_seen = rd;
         if (ew && !wait_req) begin
            left--;
            if (left == 0) begin
               job = 0; done_at = cyc + 1; free_at = cyc + 2;
            end
         end else if (!job && cyc >= free_at && sz > 0 && q[0].pc < cyc) begin
            jc = q.pop_front();
            if (jc.bytes == 0) begin
               done_at = cyc + 2; free_at = cyc + 3;
            end else if (jc.bytes > 65504) begin
               err_at = cyc + 1; free_at = cyc + 2;
            end else begin
               job = 1; wfrom = cyc + 2;
               left = (jc.bytes + 31) / 32; total = left;
            end
         end
         if (cmd_req && sz < 32) q.push_back('{bytes: cmd_bytes, addr: cmd_addr, pc: cyc});
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_cmd(input int unsigned b, input logic [31:0] a);
      cmd_req = 1'b1; cmd_bytes = b[15:0]; cmd_addr = a;
      tick();
      cmd_req = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      tick();
      while (busy && n < budget) begin tick(); n++; end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
      end
      tick();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int d0, e0, b0, p0;
      int unsigned b;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();

      // 64 bytes, 2 words ready
      d0 = n_done; b0 = n_beats; p0 = n_pops;
      dq.push_back(rword()); dq.push_back(rword());
      push_cmd(64, 32'h1000);
      wait_idle(100);
      chk("t1_beats", n_beats - b0, 2);
      chk("t1_pops", n_pops - p0, 2);
      chk("t1_done", n_done - d0, 1);
      chk("t1_addr", seen_addr, 32'h1000);
      chk("t1_bcount", seen_bc, 2);

      // 70 bytes: partial last beat
      d0 = n_done; b0 = n_beats;
      repeat (3) dq.push_back(rword());
      push_cmd(70, 32'h2000);
      wait_idle(100);
      chk("t2_beats", n_beats - b0, 3);
      chk("t2_last_be", seen_be, 32'h0000_003F);
      chk("t2_bcount", seen_bc, 3);
      chk("t2_done", n_done - d0, 1);

      // 96 bytes: data starved, then waitrequest on beat 2
      d0 = n_done; p0 = n_pops;
      push_cmd(96, 32'h3000);
      repeat (7) tick();
      repeat (3) dq.push_back(rword());
      wait_s.push_back(0); wait_s.push_back(1); wait_s.push_back(1); wait_s.push_back(1);
      wait_idle(100);
      chk("t3_pops", n_pops - p0, 3);
      chk("t3_done", n_done - d0, 1);

      // 34 back-to-back commands with no data: FIFO fills, last push dropped
      d0 = n_done; b0 = n_beats;
      for (int i = 0; i < 34; i++) begin
         cmd_req = 1'b1; cmd_bytes = 16'd32; cmd_addr = 32'h10000 + 32'(i * 32);
         tick();
      end
      cmd_req = 1'b0;
      chk("t4_full", full, 1);
      auto_fill = 1;
      wait_idle(2000);
      chk("t4_done", n_done - d0, 33);
      chk("t4_beats", n_beats - b0, 33);
      chk("t4_last_addr", seen_addr, 32'h10000 + 32 * 32);

      // zero length, oversize, then a normal single beat
      auto_fill = 0; dq.delete();
      d0 = n_done; e0 = n_err; b0 = n_beats;
      push_cmd(0, 32'h4000);
      push_cmd(65535, 32'h5000);
      dq.push_back(rword());
      push_cmd(32, 32'h6000);
      wait_idle(100);
      chk("t5_done", n_done - d0, 2);
      chk("t5_err", n_err - e0, 1);
      chk("t5_beats", n_beats - b0, 1);

      // byte-count limit: 65505 rejected, 65504 is 2047 full beats
      e0 = n_err; b0 = n_beats;
      auto_fill = 1;
      push_cmd(65505, 32'h8000);
      push_cmd(65504, 32'h9000);
      wait_idle(6000);
      chk("t6_err", n_err - e0, 1);
      chk("t6_beats", n_beats - b0, 2047);
      chk("t6_bcount", seen_bc, 2047);
      chk("t6_last_be", seen_be, 32'hFFFF_FFFF);

      // random traffic
      wait_pct = 30; starve_pct = 20;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 9))
               0:       b = 0;
               1:       b = 65505 + $urandom_range(0, 30);
               default: b = $urandom_range(1, 400);
            endcase
            cmd_req = 1'b1; cmd_bytes = b[15:0]; cmd_addr = {$urandom_range(0, 32'h7FF_FFFF), 5'd0};
         end else begin
            cmd_req = 1'b0;
         end
         tick();
      end
      cmd_req = 1'b0;
      wait_idle(20000);

      // reset in the middle of a 4-beat burst
      wait_pct = 0; starve_pct = 0; auto_fill = 0; dq.delete();
      repeat (4) dq.push_back(rword());
      push_cmd(128, 32'h7000);
      repeat (3) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_wr", wr, 0);
      chk("rst_async_rd", rd, 0);
      chk("rst_async_done", done, 0);
      chk("rst_async_busy", busy, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      b0 = n_beats;
      repeat (10) tick();
      chk("post_rst_beats", n_beats - b0, 0);
      chk("post_rst_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
